expr_nest_check: RTL

EXPR_NEST_CHECK -- requirements
Module: expr_nest_check

---
 rtl/expr_pkg.sv | 25 ++
 rtl/expr_char_class.sv | 23 ++
 rtl/expr_nest_check.sv | 135 +++++++++++++
 3 files changed

// File: rtl/expr_pkg.sv
// Shared types and constants for the expression nesting checker.
package expr_pkg;

    typedef enum logic [1:0] {
        EXPECT = 2'd0,
        OPND   = 2'd1,
        ERR    = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        DIG = 3'd0,
        OP  = 3'd1,
        LP  = 3'd2,
        RP  = 3'd3,
        BAD = 3'd4
    } char_class_e;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_STAR = 8'h2A;
    localparam logic [7:0] CH_LP   = 8'h28;
    localparam logic [7:0] CH_RP   = 8'h29;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII character classifier for the expression checker.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0]  ch,
    output char_class_e cls
);

    // Map one ASCII code onto its grammar class.
    always_comb begin
        cls = BAD;
        if (ch >= CH_0 && ch <= CH_9) begin
            cls = DIG;
        end else if (ch == CH_PLUS || ch == CH_STAR) begin
            cls = OP;
        end else if (ch == CH_LP) begin
            cls = LP;
        end else if (ch == CH_RP) begin
            cls = RP;
        end
    end

endmodule

// File: rtl/expr_nest_check.sv
// Streaming checker for arithmetic expressions with bounded parenthesis nesting.
// Optional macro EXPR_ERRPOS_EN adds err_pos, the index of the first offending character.
//
// state  | meaning
// EXPECT | an operand or '(' must come next
// OPND   | just consumed an operand digit or ')'
// ERR    | illegal input seen; absorbing until clr
module expr_nest_check
    import expr_pkg::*;
#(
    parameter int MAX_DEPTH   = 7,
    parameter int MULTI_DIGIT = 1,
    parameter int CW          = 16,
    localparam int DW         = $clog2(MAX_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [7:0]    in,
    output logic          out,
    output logic          err,
    output logic [DW-1:0] depth,
`ifdef EXPR_ERRPOS_EN
    output logic [CW-1:0] err_pos,
`endif
    output logic [CW-1:0] cnt
);

    localparam logic [DW-1:0] MAX_D   = DW'(MAX_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = '1;

    char_class_e   cls;
    state_e        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          last_rp_q, last_rp_d;
`ifdef EXPR_ERRPOS_EN
    logic [CW-1:0] err_pos_q, err_pos_d;
`endif

    expr_char_class u_class (
        .ch  (in),
        .cls (cls)
    );

    // Next-state, nesting depth, character count and registered result.
    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        last_rp_d = last_rp_q;
`ifdef EXPR_ERRPOS_EN
        err_pos_d = err_pos_q;
`endif
        if (in_valid) begin
            cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            last_rp_d = (cls == RP);
            unique case (state_q)
                EXPECT: begin
                    case (cls)
                        DIG: state_d = OPND;
                        LP: begin
                            if (depth_q == MAX_D) begin
                                state_d = ERR;
                            end else begin
                                depth_d = depth_q + DW'(1);
                            end
                        end
                        default: state_d = ERR;
                    endcase
                end
                OPND: begin
                    case (cls)
                        // A digit after ')' is juxtaposition, never legal.
                        DIG: begin
                            if (MULTI_DIGIT == 0 || last_rp_q) begin
                                state_d = ERR;
                            end
                        end
                        OP: state_d = EXPECT;
                        RP: begin
                            if (depth_q == '0) begin
                                state_d = ERR;
                            end else begin
                                depth_d = depth_q - DW'(1);
                            end
                        end
                        default: state_d = ERR;
                    endcase
                end
                default: state_d = ERR;
            endcase
            out_d = (state_d == OPND) && (depth_d == '0);
`ifdef EXPR_ERRPOS_EN
            if (state_q != ERR && state_d == ERR) begin
                err_pos_d = cnt_q;
            end
`endif
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= EXPECT;
            depth_q   <= '0;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            last_rp_q <= 1'b0;
`ifdef EXPR_ERRPOS_EN
            err_pos_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            depth_q   <= depth_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            last_rp_q <= last_rp_d;
`ifdef EXPR_ERRPOS_EN
            err_pos_q <= err_pos_d;
`endif
        end
    end

    assign out   = out_q;
    assign err   = (state_q == ERR);
    assign depth = depth_q;
    assign cnt   = cnt_q;
`ifdef EXPR_ERRPOS_EN
    assign err_pos = err_pos_q;
`endif

endmodule
